ssd_scan_driver: RTL and testbench
==================================

# ssd_scan_driver

Downstream consumer of the pipelined core's 13-bit `ssd` display value. Converts the binary value to four BCD digits with a sequential shift-add-3 (double-dabble) engine, holds the result in a display register, and time-multiplexes the digits onto a 4-digit common-anode seven-segment display. It sits between the datapath's `ssd` output and the board's anode/cathode pins.

## Interface
Parameters:
- `REFRESH_DIV`, 100000 — clock cycles each digit is lit (1 ms at 100 MHz); must be ≥ 2.
- `BLANK_LZ`, 1 — 1: blank leading zeros (digit 0 always shown); 0: show all four digits.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `value`  in  13  binary value to display, 0..8191.
- `anode`  out  4  digit enables, active low; `anode[0]` is the rightmost (units) digit.
- `cathode`  out  7  segments {g,f,e,d,c,b,a}, active low.
- `busy`  out  1  high while a conversion is in progress.
- `done`  out  1  one-cycle pulse when the display register updates.

## Operation
- Registers: `last_value[12:0]`, `shreg[28:0]` (BCD[15:0] & binary[12:0]), `iter[3:0]`, `disp_bcd[15:0]`, `refresh_cnt`, `digit_sel[1:0]`, `state`.
- FSM states: IDLE, CONV, LOAD.
  - IDLE: if `value != last_value`, capture `shreg <= {16'b0, value}`, `last_value <= value`, `iter <= 0`, go to CONV. Otherwise stay.
  - CONV: per cycle, add 3 to each BCD nibble ≥ 5, then shift `shreg` left one bit (both within one cycle). Increment `iter`; after the 13th iteration (`iter == 12`) go to LOAD.
  - LOAD: `disp_bcd <= shreg[28:13]`, assert `done`, go to IDLE.
- Changes to `value` during CONV or LOAD are ignored; the new value is detected in the next IDLE cycle because `last_value` differs from it.
- `busy` = (state != IDLE). `done` is registered and high only for the cycle after the LOAD edge.
- Scan: `refresh_cnt` counts 0..REFRESH_DIV-1 and wraps; on wrap, `digit_sel` increments modulo 4 (3→0).
- `anode = ~(4'b0001 << digit_sel)`. `cathode` is the seven-segment decode of nibble `disp_bcd[4*digit_sel +: 4]` (0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000). Any nibble > 9 decodes to blank (1111111).
- Blanking with BLANK_LZ=1: digit k (k ≥ 1) is blank (1111111) when it and all higher digits are zero. Digit 0 is never blanked. The anode still pulses for a blanked digit.
- `anode` and `cathode` decode combinationally from registered `digit_sel` and `disp_bcd`; there is no extra output register.

## Timing
- Reset values: state IDLE, `last_value` 0, `disp_bcd` 0, `shreg` 0, `iter` 0, `refresh_cnt` 0, `digit_sel` 0, `busy` 0, `done` 0, `anode` 1110, `cathode` 1000000 (shows "0"; other digits blank when BLANK_LZ=1).
- Latency: a new value is sampled at edge E0 (IDLE). `busy` is high after E0 through the E14 edge. CONV occupies E1..E13, LOAD is at E14, `disp_bcd` is valid and `done` is high after E14, and `busy` falls after E14. Total 14 cycles from sample to display update.
- Back-to-back: the earliest next sample is E15.
- Reset asserted mid-conversion aborts the conversion. The display returns to 0 with no `done` pulse. A `value` still held at nonzero after reset release is re-converted because `last_value` is now 0.
- The scan continues independently of conversion. `disp_bcd` changes only at LOAD, so a digit never shows a partial conversion.
- Each digit is lit for exactly REFRESH_DIV cycles. The full frame is 4·REFRESH_DIV cycles.

## Test plan
- Reset: hold `rst` for 2 cycles with `value`=0 -> `anode`=1110, `cathode`=1000000, `busy`=0, `done`=0, and no conversion starts after release.
- Basic conversion (REFRESH_DIV=4): drive `value`=1234 -> `busy` high for 14 cycles, one `done` pulse, `disp_bcd`=16'h1234. Over 16 cycles the digits show 4, 3, 2, 1 on anodes 1110, 1101, 1011, 0111.
- Maximum value: `value`=8191 -> `disp_bcd`=16'h8191. Cathodes for digits 0..3 are 1111001, 0010000, 1111001, 0000000.
- Leading-zero blanking: `value`=7 with BLANK_LZ=1 -> digit 0 = 1111000, digits 1–3 = 1111111. With BLANK_LZ=0, digits 1–3 = 1000000.
- Change during conversion: `value`=100, then `value`=55 at E5 -> first `done` at E14 with `disp_bcd`=0x0100. A new sample at E15 leads to a second `done` at E29 with 0x0055.
- Reset mid-conversion: `value`=4321, assert `rst` at E6 for 1 cycle -> no `done` and `disp_bcd`=0. After release, 4321 is re-converted and `done` occurs 15 cycles after `rst` deasserts.

Source files
------------

// File: rtl/ssd_scan_driver.sv
// Binary-to-BCD (double-dabble) converter with a display register and a
// time-multiplexed 4-digit common-anode seven-segment scan.
module ssd_scan_driver #(
  parameter int REFRESH_DIV = 100000,
  parameter bit BLANK_LZ    = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [12:0] value,
  output logic [3:0]  anode,
  output logic [6:0]  cathode,
  output logic        busy,
  output logic        done
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  typedef enum logic [1:0] {IDLE, CONV, LOAD} state_t;

  state_t         state, state_nxt;
  logic [12:0]    last_value;
  logic [28:0]    shreg;
  logic [28:0]    shreg_adj;
  logic [3:0]     iter;
  logic [15:0]    disp_bcd;
  logic [CW-1:0]  refresh_cnt;
  logic [1:0]     digit_sel;
  logic [3:0]     nibble;
  logic [15:0]    upper;
  logic           blank;

  function automatic logic [15:0] add3(input logic [15:0] bcd);
    logic [15:0] r;
    r = bcd;
    for (int i = 0; i < 4; i++)
      if (bcd[4*i +: 4] >= 4'd5) r[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (value != last_value) state_nxt = CONV;
      CONV:    if (iter == 4'd12) state_nxt = LOAD;
      LOAD:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
  end

  // Add-3 correction and shift happen in the same cycle.
  always_comb begin
    shreg_adj = {add3(shreg[28:13]), shreg[12:0]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_value <= '0;
      shreg      <= '0;
      iter       <= '0;
      disp_bcd   <= '0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (value != last_value) begin
            shreg      <= {16'b0, value};
            last_value <= value;
            iter       <= '0;
          end
        end
        CONV: begin
          shreg <= {shreg_adj[27:0], 1'b0};
          iter  <= iter + 4'd1;
        end
        LOAD: begin
          disp_bcd <= shreg[28:13];
          done     <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      refresh_cnt <= '0;
      digit_sel   <= '0;
    end else if (refresh_cnt == CW'(REFRESH_DIV - 1)) begin
      refresh_cnt <= '0;
      digit_sel   <= digit_sel + 2'd1;
    end else begin
      refresh_cnt <= refresh_cnt + CW'(1);
    end
  end

  // A digit is a leading zero when it and every higher digit are zero.
  always_comb begin
    anode  = ~(4'b0001 << digit_sel);
    nibble = disp_bcd[{digit_sel, 2'b00} +: 4];
    upper  = disp_bcd >> {digit_sel, 2'b00};
    blank  = BLANK_LZ && (digit_sel != 2'd0) && (upper == 16'd0);
    case (nibble)
      4'd0:    cathode = 7'b1000000;
      4'd1:    cathode = 7'b1111001;
      4'd2:    cathode = 7'b0100100;
      4'd3:    cathode = 7'b0110000;
      4'd4:    cathode = 7'b0011001;
      4'd5:    cathode = 7'b0010010;
      4'd6:    cathode = 7'b0000010;
      4'd7:    cathode = 7'b1111000;
      4'd8:    cathode = 7'b0000000;
      4'd9:    cathode = 7'b0010000;
      default: cathode = 7'b1111111;
    endcase
    if (blank) cathode = 7'b1111111;
  end

endmodule

// File: tb/tb_ssd_scan_driver.sv
// Bench for ssd_scan_driver: two instances (leading-zero blanking on/off)
// compared each cycle against a decimal/latency reference model.
module tb_ssd_scan_driver;

  localparam int RD = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [12:0] value;
  logic [3:0]  anode_lz, anode_nz;
  logic [6:0]  cathode_lz, cathode_nz;
  logic        busy_lz, busy_nz, done_lz, done_nz;

  int n_vec = 0;
  int n_err = 0;

  ssd_scan_driver #(.REFRESH_DIV(RD), .BLANK_LZ(1'b1)) dut_lz (
    .clk(clk), .rst(rst), .value(value),
    .anode(anode_lz), .cathode(cathode_lz), .busy(busy_lz), .done(done_lz));

  ssd_scan_driver #(.REFRESH_DIV(RD), .BLANK_LZ(1'b0)) dut_nz (
    .clk(clk), .rst(rst), .value(value),
    .anode(anode_nz), .cathode(cathode_nz), .busy(busy_nz), .done(done_nz));

  always #5 clk = ~clk;

  // Reference model: decimal display value plus a cycles-remaining latency counter.
  int m_last = 0, m_pend = 0, m_left = 0, m_disp = 0, m_scan = 0;
  bit m_done = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_last = 0; m_left = 0; m_disp = 0; m_done = 1'b0; m_scan = 0;
    end else begin
      m_scan++;
      m_done = 1'b0;
      if (m_left == 0) begin
        if (int'(value) != m_last) begin
          m_last = int'(value);
          m_pend = int'(value);
          m_left = 14;
        end
      end else begin
        m_left--;
        if (m_left == 0) begin
          m_disp = m_pend;
          m_done = 1'b1;
        end
      end
    end
  end

  function automatic logic [6:0] exp_cathode(input int disp, input int sel, input bit lz);
    logic [6:0] seg [10];
    int pw [4];
    seg = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
            7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    pw  = '{1, 10, 100, 1000};
    if (lz && sel > 0 && disp < pw[sel]) return 7'b1111111;
    return seg[(disp / pw[sel]) % 10];
  endfunction

  task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    int sel;
    logic [3:0] an;
    sel = (m_scan / RD) % 4;
    an  = ~(4'b0001 << sel);
    check_eq("anode_lz",   16'(anode_lz),   16'(an));
    check_eq("anode_nz",   16'(anode_nz),   16'(an));
    check_eq("cathode_lz", 16'(cathode_lz), 16'(exp_cathode(m_disp, sel, 1'b1)));
    check_eq("cathode_nz", 16'(cathode_nz), 16'(exp_cathode(m_disp, sel, 1'b0)));
    check_eq("busy_lz",    16'(busy_lz),    16'(m_left != 0));
    check_eq("busy_nz",    16'(busy_nz),    16'(m_left != 0));
    check_eq("done_lz",    16'(done_lz),    16'(m_done));
    check_eq("done_nz",    16'(done_nz),    16'(m_done));
  endtask

  // Drive inputs at a falling edge, let one rising edge pass, check at the next falling edge.
  task automatic tick(input logic r, input logic [12:0] v);
    rst   = r;
    value = v;
    @(negedge clk);
    check_all();
  endtask

  task automatic hold(input logic [12:0] v, input int n);
    for (int i = 0; i < n; i++) tick(1'b0, v);
  endtask

  initial begin
    logic [12:0] v;
    rst   = 1'b1;
    value = '0;
    @(negedge clk);
    check_all();
    tick(1'b1, 13'd0);
    hold(13'd0, 8);

    hold(13'd1234, 24);
    hold(13'd8191, 24);
    hold(13'd7, 24);
    hold(13'd1000, 20);
    hold(13'd0, 20);

    hold(13'd100, 5);
    hold(13'd55, 40);

    hold(13'd4321, 6);
    tick(1'b1, 13'd4321);
    hold(13'd4321, 24);

    v = 13'd9;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0)
        v = 13'($urandom_range(0, 8191) >> $urandom_range(0, 12));
      tick($urandom_range(0, 299) == 0, v);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
